// File: rtl/credit_stats_mc.sv
// rtl/credit_stats_mc.sv - per-channel credit counters with interval min/max/time-at-min statistics
// Optional zero-credit statistics are compiled in with `define CREDIT_ZERO_STATS_EN.
module credit_stats_mc #(
  parameter int                NUM_CH     = 4,
  parameter int                CNT_W      = 32,
  parameter logic [CNT_W-1:0]  RST_CREDIT = CNT_W'('h1000000)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         iFRAME,
  input  logic [NUM_CH-1:0]         iRRDY,
  input  logic [NUM_CH-1:0]         iLOSIG,
  input  logic [NUM_CH-1:0]         iLINK_UP_EVENT,
  input  logic                      iSTATS_LATCH_CLR,
  input  logic [NUM_CH*CNT_W-1:0]   iREG_CREDITSTART,
  output logic [NUM_CH*CNT_W-1:0]   oENDCR,
  output logic [NUM_CH*CNT_W-1:0]   oMINCR,
  output logic [NUM_CH*CNT_W-1:0]   oMAXCR,
  output logic [NUM_CH*CNT_W-1:0]   oTIMECR,
`ifdef CREDIT_ZERO_STATS_EN
  output logic [NUM_CH*CNT_W-1:0]   oZEROCNT,
  output logic [NUM_CH*CNT_W-1:0]   oZEROTIME,
`endif
  output logic                      oSTATS_VAL
);

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_CH*CNT_W-1:0] start_q;
  logic [NUM_CH-1:0]       new_start_r;
  logic [NUM_CH-1:0]       start_chg;
  logic [NUM_CH-1:0]       frm;
  logic [NUM_CH-1:0]       rdy;
  logic [NUM_CH-1:0]       reload;

  logic [CNT_W-1:0] credit_ctr [NUM_CH];
  logic [CNT_W-1:0] min_r      [NUM_CH];
  logic [CNT_W-1:0] max_r      [NUM_CH];
  logic [CNT_W-1:0] time_r     [NUM_CH];

  always_comb begin
    frm    = iFRAME & ~iLOSIG;
    rdy    = iRRDY & ~iLOSIG;
    reload = new_start_r | iLINK_UP_EVENT;
    start_chg = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      start_chg[n] = |(iREG_CREDITSTART[n*CNT_W +: CNT_W] ^ start_q[n*CNT_W +: CNT_W]);
    end
  end

  // Statistics track the registered counter, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= '0;
      new_start_r <= '0;
      oSTATS_VAL  <= 1'b0;
      oENDCR      <= '0;
      oMINCR      <= '0;
      oMAXCR      <= '0;
      oTIMECR     <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        credit_ctr[n] <= RST_CREDIT;
        min_r[n]      <= ONES;
        max_r[n]      <= '0;
        time_r[n]     <= '0;
      end
    end else begin
      start_q     <= iREG_CREDITSTART;
      new_start_r <= start_chg;
      oSTATS_VAL  <= iSTATS_LATCH_CLR;
      for (int n = 0; n < NUM_CH; n++) begin
        if (reload[n]) begin
          credit_ctr[n] <= iREG_CREDITSTART[n*CNT_W +: CNT_W];
        end else if (frm[n] && !rdy[n] && credit_ctr[n] != '0) begin
          credit_ctr[n] <= credit_ctr[n] - ONE;
        end else if (rdy[n] && !frm[n] && credit_ctr[n] != ONES) begin
          credit_ctr[n] <= credit_ctr[n] + ONE;
        end

        if (iSTATS_LATCH_CLR || reload[n]) begin
          min_r[n]  <= ONES;
          max_r[n]  <= '0;
          time_r[n] <= '0;
        end else begin
          if (credit_ctr[n] < min_r[n]) min_r[n] <= credit_ctr[n];
          if (credit_ctr[n] > max_r[n]) max_r[n] <= credit_ctr[n];
          if (credit_ctr[n] < min_r[n]) begin
            time_r[n] <= ONE;
          end else if (credit_ctr[n] == min_r[n] && time_r[n] != ONES) begin
            time_r[n] <= time_r[n] + ONE;
          end
        end

        if (iSTATS_LATCH_CLR) begin
          oENDCR[n*CNT_W +: CNT_W]  <= credit_ctr[n];
          oMINCR[n*CNT_W +: CNT_W]  <= min_r[n];
          oMAXCR[n*CNT_W +: CNT_W]  <= max_r[n];
          oTIMECR[n*CNT_W +: CNT_W] <= time_r[n];
        end
      end
    end
  end

`ifdef CREDIT_ZERO_STATS_EN
  logic [NUM_CH-1:0] zero_q;
  logic [CNT_W-1:0]  zerocnt_r  [NUM_CH];
  logic [CNT_W-1:0]  zerotime_r [NUM_CH];

  // zero_q remembers whether the counter was already empty, so only entries into zero are counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q    <= {NUM_CH{RST_CREDIT == '0}};
      oZEROCNT  <= '0;
      oZEROTIME <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        zerocnt_r[n]  <= '0;
        zerotime_r[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        zero_q[n] <= (credit_ctr[n] == '0);
        if (iSTATS_LATCH_CLR || reload[n]) begin
          zerocnt_r[n]  <= '0;
          zerotime_r[n] <= '0;
        end else begin
          if (credit_ctr[n] == '0 && !zero_q[n] && zerocnt_r[n] != ONES)
            zerocnt_r[n] <= zerocnt_r[n] + ONE;
          if (credit_ctr[n] == '0 && zerotime_r[n] != ONES)
            zerotime_r[n] <= zerotime_r[n] + ONE;
        end
        if (iSTATS_LATCH_CLR) begin
          oZEROCNT[n*CNT_W +: CNT_W]  <= zerocnt_r[n];
          oZEROTIME[n*CNT_W +: CNT_W] <= zerotime_r[n];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_credit_stats_mc.sv
// tb/tb_credit_stats_mc.sv - directed-vector bench for credit_stats_mc with NUM_CH=2, CNT_W=16
module tb_credit_stats_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  frame, rrdy, losig, link_up;
  logic        latch_clr;
  logic [31:0] start;
  logic [31:0] endcr, mincr, maxcr, timecr;
`ifdef CREDIT_ZERO_STATS_EN
  logic [31:0] zerocnt, zerotime;
`endif
  logic        stats_val;

  int errors = 0;
  int checks = 0;

  credit_stats_mc #(.NUM_CH(2), .CNT_W(16), .RST_CREDIT(16'h1234)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .iFRAME(frame),
    .iRRDY(rrdy),
    .iLOSIG(losig),
    .iLINK_UP_EVENT(link_up),
    .iSTATS_LATCH_CLR(latch_clr),
    .iREG_CREDITSTART(start),
    .oENDCR(endcr),
    .oMINCR(mincr),
    .oMAXCR(maxcr),
    .oTIMECR(timecr),
`ifdef CREDIT_ZERO_STATS_EN
    .oZEROCNT(zerocnt),
    .oZEROTIME(zerotime),
`endif
    .oSTATS_VAL(stats_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic latch();
    latch_clr = 1'b1;
    tick();
    latch_clr = 1'b0;
    check("stats_val_pulse", {31'd0, stats_val}, 32'd1);
  endtask

  function automatic logic [15:0] ch(input logic [31:0] v, input int n);
    return v[n*16 +: 16];
  endfunction

  initial begin
    rst_n = 1'b0; frame = '0; rrdy = '0; losig = '0; link_up = '0;
    latch_clr = 1'b0; start = '0;
    #12;
    check("rst_endcr",  endcr,  32'd0);
    check("rst_mincr",  mincr,  32'd0);
    check("rst_timecr", timecr, 32'd0);
    check("rst_val",    {31'd0, stats_val}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Reload both channels: ch0=8, ch1=20; 3 frames then 1 rrdy on ch0
    start = {16'd20, 16'd8};
    tick(2);
    frame = 2'b01;
    tick(3);
    frame = 2'b00; rrdy = 2'b01;
    tick();
    rrdy = 2'b00;
    latch();
    check("a_end0",  ch(endcr, 0),  16'd6);
    check("a_min0",  ch(mincr, 0),  16'd5);
    check("a_max0",  ch(maxcr, 0),  16'd8);
    check("a_time0", ch(timecr, 0), 16'd1);
    check("a_end1",  ch(endcr, 1),  16'd20);
    check("a_min1",  ch(mincr, 1),  16'd20);
    check("a_time1", ch(timecr, 1), 16'd4);
    tick();
    check("a_val_low", {31'd0, stats_val}, 32'd0);

    // Underflow hold at 0 on ch0, overflow hold at FFFF on ch1
    start = {16'hFFFF, 16'd1};
    tick(2);
    frame = 2'b01; rrdy = 2'b10;
    tick(3);
    frame = 2'b00; rrdy = 2'b00;
    tick();
    latch();
    check("b_end0",  ch(endcr, 0),  16'd0);
    check("b_min0",  ch(mincr, 0),  16'd0);
    check("b_max0",  ch(maxcr, 0),  16'd1);
    check("b_time0", ch(timecr, 0), 16'd3);
    check("b_end1",  ch(endcr, 1),  16'hFFFF);
    check("b_max1",  ch(maxcr, 1),  16'hFFFF);
    check("b_time1", ch(timecr, 1), 16'd4);

    // Simultaneous frame+rrdy, then frame under loss of signal: no change
    start = {16'hFFFF, 16'd50};
    tick(2);
    frame = 2'b01; rrdy = 2'b01;
    tick();
    rrdy = 2'b00; losig = 2'b01;
    tick();
    frame = 2'b00; losig = 2'b00;
    tick();
    latch();
    check("c_end0", ch(endcr, 0), 16'd50);
    check("c_min0", ch(mincr, 0), 16'd50);
    check("c_max0", ch(maxcr, 0), 16'd50);
    check("c_end1", ch(endcr, 1), 16'hFFFF);
    check("c_max1", ch(maxcr, 1), 16'hFFFF);

    // Minimum of 4 held for 10 cycles, then back-to-back latches
    start = {16'hFFFF, 16'd4};
    tick(2);
    tick(10);
    latch();
    check("d_time0", ch(timecr, 0), 16'd10);
    check("d_min0",  ch(mincr, 0),  16'd4);
    latch();
    check("d_clr_min0",  ch(mincr, 0),  16'hFFFF);
    check("d_clr_max0",  ch(maxcr, 0),  16'd0);
    check("d_clr_time0", ch(timecr, 0), 16'd0);
    tick();
    check("d_val_low", {31'd0, stats_val}, 32'd0);

    // Link-up on ch1 loads its start value and clears its stats
    start = {16'd20, 16'd4};
    link_up = 2'b10;
    tick();
    link_up = 2'b00;
    latch();
    check("e_end1",  ch(endcr, 1),  16'd20);
    check("e_min1",  ch(mincr, 1),  16'hFFFF);
    check("e_max1",  ch(maxcr, 1),  16'd0);
    check("e_time1", ch(timecr, 1), 16'd0);
    check("e_end0",  ch(endcr, 0),  16'd4);

`ifdef CREDIT_ZERO_STATS_EN
    // ch0 sits at zero for 3 cycles, then for 2 cycles
    start = {16'd20, 16'd1};
    tick(2);
    frame = 2'b01; tick(); frame = 2'b00;
    tick(2);
    rrdy = 2'b01; tick(); rrdy = 2'b00;
    frame = 2'b01; tick(); frame = 2'b00;
    tick();
    rrdy = 2'b01; tick(); rrdy = 2'b00;
    latch();
    check("z_cnt0",  ch(zerocnt, 0),  16'd2);
    check("z_time0", ch(zerotime, 0), 16'd5);
    check("z_cnt1",  ch(zerocnt, 1),  16'd0);
    check("z_end0",  ch(endcr, 0),    16'd1);
`endif

    // Asynchronous reset mid-run while outputs are nonzero
    latch();
    rst_n = 1'b0;
    #1;
    check("r_endcr",  endcr,  32'd0);
    check("r_mincr",  mincr,  32'd0);
    check("r_maxcr",  maxcr,  32'd0);
    check("r_timecr", timecr, 32'd0);
    check("r_val",    {31'd0, stats_val}, 32'd0);
    start = '0;
    tick();
    rst_n = 1'b1;
    tick(2);
    latch();
    check("r_end0",  ch(endcr, 0),  16'h1234);
    check("r_min0",  ch(mincr, 0),  16'h1234);
    check("r_max0",  ch(maxcr, 0),  16'h1234);
    check("r_time0", ch(timecr, 0), 16'd2);
    check("r_end1",  ch(endcr, 1),  16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
